// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg
//   Shared defaults and sizing helpers for the slide-switch debouncer.
//   CLK_HZ_DEFAULT       : system clock frequency (clk_clk domain)
//   TICK_HZ_DEFAULT      : debounce sample rate
//   STABLE_TICKS_DEFAULT : consecutive differing samples needed to accept a level
//   cnt_width()          : bits needed to hold 0..stable_ticks (never below 1)
package switch_debouncer_pkg;

  localparam int CLK_HZ_DEFAULT       = 50000000;
  localparam int TICK_HZ_DEFAULT      = 1000;
  localparam int STABLE_TICKS_DEFAULT = 10;

  function automatic int cnt_width(input int stable_ticks);
    int w;
    w = $clog2(stable_ticks + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// debounce_bit
//   One switch bit: 2-FF synchroniser, agreement counter and debounced level.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     tick       : one-cycle sample strobe from the shared prescaler
//     raw_in     : asynchronous switch level
//     init_bit   : reset value of the synchroniser and the level register
//     level_out  : debounced level
//     rise_out   : one-cycle pulse, aligned with level_out going 0->1
//     fall_out   : one-cycle pulse, aligned with level_out going 1->0
//     cnt_dbg    : current disagreement count (observation only)
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter int CW           = cnt_width(STABLE_TICKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          raw_in,
  input  logic          init_bit,
  output logic          level_out,
  output logic          rise_out,
  output logic          fall_out,
  output logic [CW-1:0] cnt_dbg
);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (sync2_q == level_q) begin
        // Any agreeing sample discards a pending change; this rejects bounce.
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= init_bit;
      sync2_q <= init_bit;
      level_q <= init_bit;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;
  assign cnt_dbg   = cnt_q;

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions the raw slide-switch bank before it reaches the switch PIO and
//   the SoC switch port. Holds the shared sample prescaler and the sticky
//   change flag; per-bit filtering lives in debounce_bit.
//   Ports:
//     clk, reset     : clock and synchronous active-high reset
//     sw_in          : raw asynchronous switch levels
//     sw_out         : debounced levels
//     sw_rise        : one-cycle pulse per bit on an accepted 0->1
//     sw_fall        : one-cycle pulse per bit on an accepted 1->0
//     change_pending : sticky, set whenever any rise/fall pulse is present
//     change_ack     : clears change_pending (a simultaneous new change wins)
//   Handshake: change_pending is a level owned by the block; firmware polls it,
//   then raises change_ack for at least one cycle. An ack sampled in a cycle
//   where a pulse is visible is ignored so no change is ever lost.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int               TICK_HZ      = TICK_HZ_DEFAULT,
  parameter int               STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter logic [WIDTH-1:0] INIT         = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             change_pending,
  input  logic             change_ack
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = cnt_width(STABLE_TICKS);

  if (DIV < 1) begin : g_bad_div
    $error("switch_debouncer: CLK_HZ/TICK_HZ must be at least 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("switch_debouncer: STABLE_TICKS must be at least 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          pending_q, pending_d;
  logic          any_pulse;

  // With DIV == 1 the counter stays at 0 and tick is high every cycle.
  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_unused;
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .CW           (CW)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .raw_in    (sw_in[i]),
      .init_bit  (INIT[i]),
      .level_out (sw_out[i]),
      .rise_out  (sw_rise[i]),
      .fall_out  (sw_fall[i]),
      .cnt_dbg   (cnt_unused)
    );
  end

  // Pulses are registered, so the flag follows one cycle after the pulse and
  // an ack in the pulse cycle loses to the set.
  assign any_pulse = (|sw_rise) | (|sw_fall);

  always_comb begin
    pending_d = pending_q;
    if (any_pulse) begin
      pending_d = 1'b1;
    end else if (change_ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pending_q <= pending_d;
    end
  end

  assign change_pending = pending_q;

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int EW = 3 * W;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         change_pending;
  logic         change_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 0;

  // expected pulse events: {sw_out, sw_rise, sw_fall}
  logic [EW-1:0] exp_q[$];

  switch_debouncer #(
    .WIDTH        (W),
    .CLK_HZ       (1000),
    .TICK_HZ      (250),
    .STABLE_TICKS (3),
    .INIT         (4'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_in          (sw_in),
    .sw_out         (sw_out),
    .sw_rise        (sw_rise),
    .sw_fall        (sw_fall),
    .change_pending (change_pending),
    .change_ack     (change_ack)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: every visible pulse must match the next expected event
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    if (started && ((sw_rise | sw_fall) != '0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: out=%h rise=%h fall=%h expected none (cycle %0d)",
                 sw_out, sw_rise, sw_fall, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        check("pulse_event", {20'h0, sw_out, sw_rise, sw_fall}, {20'h0, exp_v});
      end
    end
  end

  // driver tasks
  task automatic drive_sw(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    sw_in = v;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1;
    change_ack = 1'b1;
    @(posedge clk);
    #1;
    change_ack = 1'b0;
  endtask

  task automatic wait_out(input logic [W-1:0] exp, input int max_cyc, output bit found);
    found = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sw_out === exp) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    int c0;
    int r0;
    bit found;

    reset      = 1'b1;
    sw_in      = 4'hF;
    change_ack = 1'b0;

    // 1: reset with all switches high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      started = 1;
      check("reset_sw_out", {28'h0, sw_out}, 32'h0);
      check("reset_pulses", {24'h0, sw_rise, sw_fall}, 32'h0);
      check("reset_pending", {31'h0, change_pending}, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sw_in = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_sw_out", {28'h0, sw_out}, 32'h0);
      check("idle_pending", {31'h0, change_pending}, 32'h0);
    end

    // 2: clean step on bit 0
    exp_q.push_back({4'h1, 4'h1, 4'h0});
    drive_sw(4'h1);
    c0 = cyc;
    wait_out(4'h1, 20, found);
    check("step_seen", {31'h0, found}, 32'h1);
    n_checks++;
    if ((cyc - c0) < 11 || (cyc - c0) > 14) begin
      n_fail++;
      $display("FAIL step_latency: got %0d cycles expected 11..14", cyc - c0);
    end
    @(negedge clk);
    check("step_pending", {31'h0, change_pending}, 32'h1);

    // 3: bounce on bit 1, synced value alternates on each tick
    for (int i = 0; i < 10; i++) begin
      drive_sw({2'b00, ~i[0], 1'b1});
      repeat (3) @(posedge clk);
    end
    drive_sw(4'h1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("bounce_sw_out", {28'h0, sw_out}, 32'h1);
    check("bounce_pending", {31'h0, change_pending}, 32'h1);

    pulse_ack();
    @(negedge clk);
    check("ack_clears", {31'h0, change_pending}, 32'h0);
    pulse_ack();
    @(negedge clk);
    check("ack_when_clear", {31'h0, change_pending}, 32'h0);

    // 4: simultaneous rise/fall on several bits
    exp_q.push_back({4'h6, 4'h6, 4'h1});
    drive_sw(4'h6);
    wait_out(4'h6, 20, found);
    check("simul_seen", {31'h0, found}, 32'h1);
    @(negedge clk);
    check("simul_pending", {31'h0, change_pending}, 32'h1);
    pulse_ack();
    @(negedge clk);
    check("simul_ack", {31'h0, change_pending}, 32'h0);

    // 5: ack in the same cycle as a fresh fall pulse
    exp_q.push_back({4'h2, 4'h0, 4'h4});
    drive_sw(4'h2);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw_fall !== 4'h0) begin
        found = 1;
        break;
      end
    end
    check("race_pulse_seen", {31'h0, found}, 32'h1);
    change_ack = 1'b1;
    @(posedge clk);
    #1;
    change_ack = 1'b0;
    @(negedge clk);
    check("race_set_wins", {31'h0, change_pending}, 32'h1);
    repeat (2) @(posedge clk);
    pulse_ack();
    @(negedge clk);
    check("late_ack", {31'h0, change_pending}, 32'h0);

    // 6: reset while bit 2 is mid-count
    drive_sw(4'h6);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    r0 = cyc;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_sw_out", {28'h0, sw_out}, 32'h0);
    check("midreset_pulses", {24'h0, sw_rise, sw_fall}, 32'h0);
    check("midreset_pending", {31'h0, change_pending}, 32'h0);
    exp_q.push_back({4'h6, 4'h6, 4'h0});
    wait_out(4'h6, 20, found);
    check("fresh_seen", {31'h0, found}, 32'h1);
    check("fresh_latency", cyc - r0, 32'd12);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
